// File: rtl/jtframe_keyjoy_pkg.sv
// Shared constants for the keyboard/joystick front end: PS/2 scan codes,
// control-vector bit layout and the key-to-latch lookup used at elaboration.
package jtframe_keyjoy_pkg;

  localparam int CNT_W = 4;

  localparam logic [7:0] KC_P1_U     = 8'h75;
  localparam logic [7:0] KC_P1_D     = 8'h72;
  localparam logic [7:0] KC_P1_L     = 8'h6B;
  localparam logic [7:0] KC_P1_R     = 8'h74;
  localparam logic [7:0] KC_P1_F0    = 8'h14;
  localparam logic [7:0] KC_P1_F1    = 8'h29;
  localparam logic [7:0] KC_P1_F2    = 8'h11;
  localparam logic [7:0] KC_P1_F3    = 8'h12;
  localparam logic [7:0] KC_P1_START = 8'h05;
  localparam logic [7:0] KC_P1_COIN  = 8'h04;
  localparam logic [7:0] KC_P2_U     = 8'h2D;
  localparam logic [7:0] KC_P2_D     = 8'h2B;
  localparam logic [7:0] KC_P2_L     = 8'h23;
  localparam logic [7:0] KC_P2_R     = 8'h34;
  localparam logic [7:0] KC_P2_F0    = 8'h1C;
  localparam logic [7:0] KC_P2_F1    = 8'h1B;
  localparam logic [7:0] KC_P2_START = 8'h06;
  localparam logic [7:0] KC_P2_COIN  = 8'h0C;

  // START and COIN sit at jw-OFS_START and jw-OFS_COIN
  localparam int BIT_R     = 0;
  localparam int BIT_L     = 1;
  localparam int BIT_D     = 2;
  localparam int BIT_U     = 3;
  localparam int BIT_FIRE0 = 4;
  localparam int OFS_START = 2;
  localparam int OFS_COIN  = 1;

  function automatic int jw(input int buttons);
    return buttons + 6;
  endfunction

  // {valid, scan code} for a given player/bit; valid=0 means no latch is built
  function automatic logic [8:0] key_code(input int player, input int bit_idx, input int buttons);
    logic [8:0] kc;
    int         n;
    kc = '0;
    n  = bit_idx - BIT_FIRE0;
    if (player == 0) begin
      if (bit_idx == jw(buttons) - OFS_COIN)       kc = {1'b1, KC_P1_COIN};
      else if (bit_idx == jw(buttons) - OFS_START) kc = {1'b1, KC_P1_START};
      else if (n >= 0 && n < buttons) begin
        case (n)
          0: kc = {1'b1, KC_P1_F0};
          1: kc = {1'b1, KC_P1_F1};
          2: kc = {1'b1, KC_P1_F2};
          3: kc = {1'b1, KC_P1_F3};
          default: kc = '0;
        endcase
      end else begin
        case (bit_idx)
          BIT_U: kc = {1'b1, KC_P1_U};
          BIT_D: kc = {1'b1, KC_P1_D};
          BIT_L: kc = {1'b1, KC_P1_L};
          BIT_R: kc = {1'b1, KC_P1_R};
          default: kc = '0;
        endcase
      end
    end else if (player == 1) begin
      if (bit_idx == jw(buttons) - OFS_COIN)       kc = {1'b1, KC_P2_COIN};
      else if (bit_idx == jw(buttons) - OFS_START) kc = {1'b1, KC_P2_START};
      else if (n >= 0 && n < buttons) begin
        case (n)
          0: kc = {1'b1, KC_P2_F0};
          1: kc = {1'b1, KC_P2_F1};
          default: kc = '0;
        endcase
      end else begin
        case (bit_idx)
          BIT_U: kc = {1'b1, KC_P2_U};
          BIT_D: kc = {1'b1, KC_P2_D};
          BIT_L: kc = {1'b1, KC_P2_L};
          BIT_R: kc = {1'b1, KC_P2_R};
          default: kc = '0;
        endcase
      end
    end
    return kc;
  endfunction

endpackage

// File: rtl/jtframe_keyjoy_stretch.sv
// Coin pulse stretcher: a rising coin edge arms a frame down-counter so the
// coin stays asserted for at least COIN_FRAMES frame ticks.
module jtframe_keyjoy_stretch
  import jtframe_keyjoy_pkg::*;
#(
  parameter int COIN_FRAMES = 4
)(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic coin_in,
  output logic coin_out
);

  logic             coin_l;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise = coin_in & ~coin_l;

  // reload has priority so a re-press always restarts the full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_l <= 1'b0;
      cnt    <= '0;
    end else begin
      coin_l <= coin_in;
      if (rise)                   cnt <= CNT_W'(COIN_FRAMES);
      else if (tick && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign coin_out = coin_in | (cnt != '0);

endmodule

// File: rtl/jtframe_keyjoy.sv
// Player-input front end: PS/2 key latches ORed with MiSTer joysticks, coin
// stretching and registered active-low outputs. Autofire: JTFRAME_AUTOFIRE_EN.
module jtframe_keyjoy
  import jtframe_keyjoy_pkg::*;
#(
  parameter  int PLAYERS     = 2,
  parameter  int BUTTONS     = 2,
  parameter  int COIN_FRAMES = 4,
  parameter  int AF_PERIOD   = 4,
  localparam int JW          = BUTTONS + 6
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           ps2_key,
  input  logic [PLAYERS*JW-1:0] joy_in,
  input  logic                  vs,
  input  logic                  merge,
  input  logic [BUTTONS-1:0]    autofire,
  output logic [PLAYERS*JW-1:0] game_joy_n
);

  logic                        tog_l, armed, key_evt;
  logic                        vs_l, tick;
  logic [PLAYERS-1:0][JW-1:0]  joy, key, raw, proc;
  logic [JW-1:0]               joy_or;
  logic [PLAYERS-1:0]          coin_out;
  logic [BUTTONS-1:0]          af_mask;
  logic                        unused_ext;

  assign joy        = joy_in;
  assign unused_ext = ps2_key[8];

  // armed keeps a toggle already high at reset release from decoding as an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_l <= 1'b0;
      armed <= 1'b0;
      vs_l  <= 1'b0;
    end else begin
      tog_l <= ps2_key[10];
      armed <= 1'b1;
      vs_l  <= vs;
    end
  end

  assign key_evt = armed & (ps2_key[10] ^ tog_l);
  assign tick    = vs & ~vs_l;

  genvar p, i;
  generate
    for (p = 0; p < PLAYERS; p++) begin : g_pl
      for (i = 0; i < JW; i++) begin : g_bit
        localparam logic [8:0] KC = key_code(p, i, BUTTONS);
        if (KC[8]) begin : g_latch
          logic kq;
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                              kq <= 1'b0;
            else if (key_evt && ps2_key[7:0] == KC[7:0]) kq <= ps2_key[9];
          end
          assign key[p][i] = kq;
        end else begin : g_none
          assign key[p][i] = 1'b0;
        end
      end

      jtframe_keyjoy_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_stretch (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .coin_in  (raw[p][JW-OFS_COIN]),
        .coin_out (coin_out[p])
      );
    end
  endgenerate

  always_comb begin
    joy_or = '0;
    for (int q = 0; q < PLAYERS; q++) joy_or = joy_or | joy[q];
  end

  always_comb begin
    raw = key | joy;
    if (merge) raw[0] = key[0] | joy_or;
  end

`ifdef JTFRAME_AUTOFIRE_EN
  logic [CNT_W-1:0] af_cnt;
  logic             af_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt <= '0;
      af_ph  <= 1'b0;
    end else if (tick) begin
      if (af_cnt == CNT_W'(AF_PERIOD - 1)) begin
        af_cnt <= '0;
        af_ph  <= ~af_ph;
      end else begin
        af_cnt <= af_cnt + 1'b1;
      end
    end
  end

  assign af_mask = {BUTTONS{af_ph}} | ~autofire;
`else
  logic unused_af;
  assign unused_af = ^autofire;
  assign af_mask   = '1;
`endif

  always_comb begin
    proc = raw;
    for (int q = 0; q < PLAYERS; q++) begin
      proc[q][BIT_FIRE0 +: BUTTONS] = raw[q][BIT_FIRE0 +: BUTTONS] & af_mask;
      proc[q][JW-OFS_COIN]          = coin_out[q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) game_joy_n <= '1;
    else        game_joy_n <= ~proc;
  end

endmodule

// File: tb/tb_jtframe_keyjoy.sv
module tb_jtframe_keyjoy;

  localparam int PL = 2;
  localparam int BT = 2;
  localparam int W  = PL * (BT + 6);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   ps2_key;
  logic [W-1:0]  joy_in;
  logic          vs;
  logic          merge;
  logic [BT-1:0] autofire;
  logic [W-1:0]  game_joy_n;

  jtframe_keyjoy #(.PLAYERS(PL), .BUTTONS(BT), .COIN_FRAMES(4), .AF_PERIOD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_key    (ps2_key),
    .joy_in     (joy_in),
    .vs         (vs),
    .merge      (merge),
    .autofire   (autofire),
    .game_joy_n (game_joy_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       nm;
  } sb_t;

  typedef struct {
    logic [15:0] joy;
    logic        mrg;
    logic [15:0] exp;
  } vec_t;

  sb_t  sbq[$];
  int   tick_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tog     = 1'b0;
  logic [15:0] cur;

  task automatic expect_at(input int due, input logic [15:0] v, input string nm);
    sb_t e;
    e.due = due; e.exp = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due == cyc) begin
        n_tests++;
        if (game_joy_n !== sbq[k].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h want %h", sbq[k].nm, cyc, game_joy_n, sbq[k].exp);
        end
        sbq.delete(k);
      end
    end
  end

  function automatic int count_ticks(input int lo, input int hi);
    int c = 0;
    foreach (tick_cyc[k]) if (tick_cyc[k] > lo && tick_cyc[k] <= hi) c++;
    return c;
  endfunction

  task automatic ps2_evt(input logic pr, input logic [7:0] code, input logic [15:0] after, input string nm);
    @(posedge clk); #2;
    tog     = ~tog;
    ps2_key = {tog, pr, 1'b0, code};
    expect_at(cyc + 1, cur, {nm, "_early"});
    expect_at(cyc + 2, after, nm);
    cur = after;
    repeat (3) @(posedge clk);
  endtask

  task automatic coin_run(input int rep_k, input string nm);
    int   last_load;
    logic have_load, prev_coin, coin, low;
    have_load = 1'b0; prev_coin = 1'b0; last_load = 0;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk); #2;
      coin   = (k == 0) || (k == rep_k);
      joy_in = coin ? 16'h8000 : 16'h0000;
      vs     = (k >= 2) && ((k - 2) % 4 == 0);
      if (vs) tick_cyc.push_back(cyc);
      low = prev_coin || (have_load && count_ticks(last_load, cyc - 2) < 4);
      expect_at(cyc, low ? 16'h7FFF : 16'hFFFF, $sformatf("%s_k%0d", nm, k));
      if (coin) begin last_load = cyc; have_load = 1'b1; end
      prev_coin = coin;
    end
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{16'h0000, 1'b0, 16'hFFFF};
    tbl[1] = '{16'h0001, 1'b0, 16'hFFFE};
    tbl[2] = '{16'h000C, 1'b0, 16'hFFF3};
    tbl[3] = '{16'h0300, 1'b0, 16'hFCFF};
    tbl[4] = '{16'h1000, 1'b0, 16'hEFFF};
    tbl[5] = '{16'h1000, 1'b1, 16'hEFEF};
    tbl[6] = '{16'h0020, 1'b1, 16'hFFDF};
    tbl[7] = '{16'h4020, 1'b1, 16'hBF9F};
    tbl[8] = '{16'h3F3F, 1'b0, 16'hC0C0};
    tbl[9] = '{16'h0000, 1'b0, 16'hFFFF};

    rst_n    = 1'b0;
    joy_in   = 16'h0001;
    ps2_key  = {1'b1, 1'b1, 1'b0, 8'h75};
    vs       = 1'b0;
    merge    = 1'b0;
    autofire = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      expect_at(cyc, 16'hFFFF, "in_reset");
      n_tests++;
      if (game_joy_n !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL in_reset_direct%0d: got %h", k, game_joy_n);
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    tog   = 1'b1;
    expect_at(cyc, 16'hFFFF, "release_edge");
    n_tests++;
    if (game_joy_n !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL release_edge_direct: got %h", game_joy_n);
    end
    for (int k = 1; k <= 4; k++) expect_at(cyc + k, 16'hFFFE, $sformatf("post_reset%0d", k));
    repeat (4) @(posedge clk);
    #2;
    joy_in = '0;
    expect_at(cyc + 1, 16'hFFFF, "idle");
    cur = 16'hFFFF;

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      joy_in = tbl[k].joy;
      merge  = tbl[k].mrg;
      expect_at(cyc + 1, tbl[k].exp, $sformatf("tbl%0d", k));
    end
    @(posedge clk); #2;
    joy_in = '0;
    merge  = 1'b0;
    expect_at(cyc + 1, 16'hFFFF, "tbl_clear");

    ps2_evt(1'b1, 8'h75, 16'hFFF7, "p1_up_press");
    ps2_evt(1'b0, 8'h75, 16'hFFFF, "p1_up_release");
    ps2_evt(1'b1, 8'h99, 16'hFFFF, "unknown_code");
    ps2_evt(1'b1, 8'h12, 16'hFFFF, "p1_f3_unbuilt");
    ps2_evt(1'b1, 8'h29, 16'hFFDF, "p1_f1_press");
    ps2_evt(1'b1, 8'h2D, 16'hF7DF, "p2_up_press");
    ps2_evt(1'b0, 8'h29, 16'hF7FF, "p1_f1_release");
    ps2_evt(1'b0, 8'h2D, 16'hFFFF, "p2_up_release");
    ps2_evt(1'b1, 8'h1C, 16'hEFFF, "p2_f0_press");
    ps2_evt(1'b0, 8'h1C, 16'hFFFF, "p2_f0_release");

    coin_run(-1, "coin");
    coin_run(6, "coin_repress");

`ifdef JTFRAME_AUTOFIRE_EN
    @(posedge clk); #2;
    autofire = 2'b01;
    joy_in   = 16'h0030;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 32; k++) begin
      int   n;
      logic ph;
      @(posedge clk); #2;
      vs = (k % 4 == 0);
      if (vs) tick_cyc.push_back(cyc);
      n  = count_ticks(-1000000, cyc - 2);
      ph = ((n / 2) % 2) == 1;
      expect_at(cyc, ~(16'h0020 | (ph ? 16'h0010 : 16'h0000)), $sformatf("autofire_k%0d", k));
    end
    @(posedge clk); #2;
    joy_in = '0;
    vs     = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #6;
    foreach (sbq[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation never checked (due %0d, now %0d)", sbq[k].nm, sbq[k].due, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
